// File: rtl/ldlt_subst_solver.sv
// LDL^T back-end solver: forward substitution, diagonal division and backward substitution
// in signed fixed point, serialised over one multiplier and one divider.
module ldlt_subst_solver #(
  parameter int N          = 6,
  parameter int BW         = 32,
  parameter int FRAC       = 16,
  parameter int MUL_STAGES = 2,
  parameter int DIV_STAGES = 3
) (
  input  logic                                               i_clk,
  input  logic                                               i_rst,
  input  logic                                               i_start,
  input  logic [N*BW-1:0]                                    i_diag,
  input  logic [((N*(N-1)/2 > 0) ? N*(N-1)/2 : 1)*BW-1:0]    i_lower,
  input  logic [N*BW-1:0]                                    i_vec,
  output logic                                               o_busy,
  output logic                                               o_done,
  output logic [N*BW-1:0]                                    o_x,
  output logic                                               o_div_zero,
  output logic                                               o_overflow
);

  localparam int NL   = N * (N - 1) / 2;
  localparam int NLS  = (NL > 0) ? NL : 1;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int LIW  = (NLS > 1) ? $clog2(NLS) : 1;
  localparam int SMAX = (MUL_STAGES > DIV_STAGES) ? MUL_STAGES : DIV_STAGES;
  localparam int CW   = $clog2(SMAX + 1);
  localparam int PW   = 2 * BW;
  localparam int QW   = BW + FRAC + 1;

  localparam logic signed [BW-1:0] MAXV = {1'b0, {(BW-1){1'b1}}};
  localparam logic signed [BW-1:0] MINV = {1'b1, {(BW-1){1'b0}}};
  localparam logic signed [PW-1:0] BIAS = PW'((64'd1 << FRAC) - 64'd1);

  typedef enum logic [2:0] {IDLE, FWD, DIAG, BWD, DONE} state_t;

  state_t state, next_state;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  row, col, kidx;
  logic [LIW-1:0] lidx;
  logic signed [BW-1:0] diag_q [N];
  logic signed [BW-1:0] lower_q [NLS];
  logic signed [BW-1:0] w [N];
  logic signed [BW-1:0] w_next [N];
  logic signed [PW-1:0] mul_pipe [MUL_STAGES];
  logic signed [QW-1:0] div_pipe [DIV_STAGES];
  logic signed [PW-1:0] biased, shifted;
  logic signed [BW:0]   diff;
  logic signed [BW-1:0] mq, sub_val, div_val;
  logic signed [QW-1:0] dividend, divisor, q;
  logic ovf_st, dz_st, ovf_next, dz_next;
  logic accept, is_mac, op_last, fwd_end, diag_end, bwd_end;
  logic mq_ovf, sub_ovf, q_ovf, d_zero;

  function automatic int tri_idx(input int hi, input int lo);
    return hi * (hi - 1) / 2 + lo;
  endfunction

  always_comb begin
    accept   = (state == IDLE) && i_start;
    is_mac   = (state == FWD) || (state == BWD);
    op_last  = is_mac ? (cnt == CW'(MUL_STAGES)) : ((state == DIAG) && (cnt == CW'(DIV_STAGES)));
    fwd_end  = (row == IW'(N - 1)) && (col == row - IW'(1));
    diag_end = (kidx == '0);
    bwd_end  = (row == '0) && (col == row + IW'(1));
    lidx     = (row > col) ? LIW'(tri_idx(int'(row), int'(col))) : LIW'(tri_idx(int'(col), int'(row)));
  end

  // mulq rounds toward zero by biasing negative products before the arithmetic shift
  always_comb begin
    biased  = mul_pipe[MUL_STAGES-1][PW-1] ? mul_pipe[MUL_STAGES-1] + BIAS : mul_pipe[MUL_STAGES-1];
    shifted = biased >>> FRAC;
    mq_ovf  = !((&shifted[PW-1:BW-1]) || (~|shifted[PW-1:BW-1]));
    mq      = mq_ovf ? (shifted[PW-1] ? MINV : MAXV) : shifted[BW-1:0];
    diff    = (BW+1)'(w[row]) - (BW+1)'(mq);
    sub_ovf = diff[BW] != diff[BW-1];
    sub_val = sub_ovf ? (diff[BW] ? MINV : MAXV) : diff[BW-1:0];
  end

  // A zero pivot divides by one to keep the datapath defined; the result is overridden at write-back
  always_comb begin
    d_zero   = (diag_q[kidx] == '0);
    dividend = QW'(w[kidx]) <<< FRAC;
    divisor  = d_zero ? QW'(1) : QW'(diag_q[kidx]);
    q        = div_pipe[DIV_STAGES-1];
    q_ovf    = !((&q[QW-1:BW-1]) || (~|q[QW-1:BW-1]));
    if (d_zero)
      div_val = w[kidx][BW-1] ? MINV : MAXV;
    else
      div_val = q_ovf ? (q[QW-1] ? MINV : MAXV) : q[BW-1:0];
  end

  always_comb begin
    w_next   = w;
    ovf_next = ovf_st;
    dz_next  = dz_st;
    if (op_last) begin
      if (is_mac) begin
        w_next[row] = sub_val;
        if (mq_ovf || sub_ovf) ovf_next = 1'b1;
      end else begin
        w_next[kidx] = div_val;
        if (d_zero) dz_next = 1'b1;
        else if (q_ovf) ovf_next = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_start) next_state = (N == 1) ? DIAG : FWD;
      FWD:     if (op_last && fwd_end) next_state = DIAG;
      DIAG:    if (op_last && diag_end) next_state = (N == 1) ? DONE : BWD;
      BWD:     if (op_last && bwd_end) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state != IDLE);
    o_done = (state == DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0; row <= '0; col <= '0; kidx <= '0;
      ovf_st <= 1'b0; dz_st <= 1'b0;
      o_x <= '0; o_overflow <= 1'b0; o_div_zero <= 1'b0;
      for (int k = 0; k < N; k++) begin
        diag_q[k] <= '0;
        w[k]      <= '0;
      end
      for (int e = 0; e < NLS; e++) lower_q[e] <= '0;
      for (int s = 0; s < MUL_STAGES; s++) mul_pipe[s] <= '0;
      for (int s = 0; s < DIV_STAGES; s++) div_pipe[s] <= '0;
    end else begin
      mul_pipe[0] <= PW'(lower_q[lidx]) * PW'(w[col]);
      for (int s = 1; s < MUL_STAGES; s++) mul_pipe[s] <= mul_pipe[s-1];
      div_pipe[0] <= dividend / divisor;
      for (int s = 1; s < DIV_STAGES; s++) div_pipe[s] <= div_pipe[s-1];

      if (accept) begin
        for (int k = 0; k < N; k++) begin
          diag_q[k] <= i_diag[k*BW +: BW];
          w[k]      <= i_vec[k*BW +: BW];
        end
        for (int e = 0; e < NLS; e++) lower_q[e] <= i_lower[e*BW +: BW];
        cnt <= '0; row <= IW'(1); col <= '0; kidx <= IW'(N - 1);
        ovf_st <= 1'b0; dz_st <= 1'b0;
        o_overflow <= 1'b0; o_div_zero <= 1'b0;
      end else if (state == FWD || state == DIAG || state == BWD) begin
        w      <= w_next;
        ovf_st <= ovf_next;
        dz_st  <= dz_next;
        if (op_last) begin
          cnt <= '0;
          case (state)
            FWD: if (!fwd_end) begin
              if (col == row - IW'(1)) begin
                row <= row + IW'(1);
                col <= '0;
              end else col <= col + IW'(1);
            end
            DIAG: if (diag_end) begin
              row <= IW'(N - 2);
              col <= IW'(N - 1);
            end else kidx <= kidx - IW'(1);
            BWD: if (!bwd_end) begin
              if (col == row + IW'(1)) begin
                row <= row - IW'(1);
                col <= IW'(N - 1);
              end else col <= col - IW'(1);
            end
            default: ;
          endcase
        end else cnt <= cnt + CW'(1);
        if (next_state == DONE) begin
          for (int k = 0; k < N; k++) o_x[k*BW +: BW] <= w_next[k];
          o_overflow <= ovf_next;
          o_div_zero <= dz_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_ldlt_subst_solver.sv
// Self-checking bench: an N=6 and an N=2 solver checked against an arithmetic LDL^T model,
// with directed corner cases, randomized solves, start-ignore and mid-solve reset.
module tb_ldlt_subst_solver;

  localparam longint MAXV = 64'sh7FFFFFFF;
  localparam longint MINV = -64'sh80000000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start6, start2;
  logic [191:0] diag6, vec6, x6;
  logic [479:0] lower6;
  logic busy6, done6, dz6, ovf6;
  logic [63:0] diag2, vec2, x2;
  logic [31:0] lower2;
  logic busy2, done2, dz2, ovf2;

  ldlt_subst_solver dut6 (
    .i_clk(clk), .i_rst(rst), .i_start(start6), .i_diag(diag6), .i_lower(lower6), .i_vec(vec6),
    .o_busy(busy6), .o_done(done6), .o_x(x6), .o_div_zero(dz6), .o_overflow(ovf6)
  );

  ldlt_subst_solver #(.N(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_diag(diag2), .i_lower(lower2), .i_vec(vec2),
    .o_busy(busy2), .o_done(done2), .o_x(x2), .o_div_zero(dz2), .o_overflow(ovf2)
  );

  int n_cmp = 0;
  int n_fail = 0;
  longint tb_d [6];
  longint tb_b [6];
  longint tb_l [6][6];
  longint exp_x [6];
  bit exp_ovf, exp_dz, m_ovf, m_dz;
  int cycles, busy_cnt, done_cnt;
  bit got_done;

  function automatic longint sat(input longint v);
    if (v > MAXV) begin m_ovf = 1'b1; return MAXV; end
    if (v < MINV) begin m_ovf = 1'b1; return MINV; end
    return v;
  endfunction

  // Reference solve in plain integer arithmetic; '/' truncates toward zero
  task automatic model_solve(input int n);
    longint w [6];
    m_ovf = 1'b0;
    m_dz  = 1'b0;
    for (int k = 0; k < n; k++) w[k] = tb_b[k];
    for (int r = 1; r < n; r++)
      for (int c = 0; c < r; c++)
        w[r] = sat(w[r] - sat((tb_l[r][c] * w[c]) / 65536));
    for (int k = n - 1; k >= 0; k--) begin
      if (tb_d[k] == 0) begin
        m_dz = 1'b1;
        w[k] = (w[k] >= 0) ? MAXV : MINV;
      end else w[k] = sat((w[k] * 65536) / tb_d[k]);
    end
    for (int r = n - 2; r >= 0; r--)
      for (int c = n - 1; c > r; c--)
        w[r] = sat(w[r] - sat((tb_l[c][r] * w[c]) / 65536));
    for (int k = 0; k < 6; k++) exp_x[k] = (k < n) ? w[k] : 0;
    exp_ovf = m_ovf;
    exp_dz  = m_dz;
  endtask

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] getx(input int n, input int k);
    return (n == 6) ? x6[k*32 +: 32] : x2[k*32 +: 32];
  endfunction
  function automatic logic busy_of(input int n);
    return (n == 6) ? busy6 : busy2;
  endfunction
  function automatic logic done_of(input int n);
    return (n == 6) ? done6 : done2;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < 6; i++) begin
      tb_d[i] = 0;
      tb_b[i] = 0;
      for (int j = 0; j < 6; j++) tb_l[i][j] = 0;
    end
  endtask

  task automatic random_inputs(input int n);
    clear_inputs();
    for (int k = 0; k < n; k++) begin
      tb_d[k] = longint'($urandom_range(32'h40000, 32'h4000));
      if ($urandom_range(1, 0) == 1) tb_d[k] = -tb_d[k];
      tb_b[k] = longint'($urandom_range(32'h400000, 0)) - 64'sh200000;
      for (int c = 0; c < k; c++) tb_l[k][c] = longint'($urandom_range(32'h20000, 0)) - 64'sh10000;
    end
  endtask

  // Packs the stimulus arrays, computes expectations and raises start for the selected DUT
  task automatic applyStimulus(input int n);
    int e;
    e = 0;
    for (int k = 0; k < n; k++) begin
      if (n == 6) begin
        diag6[k*32 +: 32] = tb_d[k][31:0];
        vec6[k*32 +: 32]  = tb_b[k][31:0];
      end else begin
        diag2[k*32 +: 32] = tb_d[k][31:0];
        vec2[k*32 +: 32]  = tb_b[k][31:0];
      end
    end
    for (int r = 1; r < n; r++)
      for (int c = 0; c < r; c++) begin
        if (n == 6) lower6[e*32 +: 32] = tb_l[r][c][31:0];
        else        lower2[e*32 +: 32] = tb_l[r][c][31:0];
        e++;
      end
    model_solve(n);
    if (n == 6) start6 = 1'b1;
    else        start2 = 1'b1;
  endtask

  // Counts cycles after the accept edge until o_done; optionally pulses start mid-solve
  task automatic waitDone(input int n, input bit poke);
    cycles = 0;
    busy_cnt = 0;
    got_done = 1'b0;
    while (!got_done && cycles < 400) begin
      @(negedge clk);
      if (cycles == 0) begin start6 = 1'b0; start2 = 1'b0; end
      cycles++;
      if (poke && cycles == 20) begin if (n == 6) start6 = 1'b1; else start2 = 1'b1; end
      if (poke && cycles == 21) begin start6 = 1'b0; start2 = 1'b0; end
      if (busy_of(n)) busy_cnt++;
      if (done_of(n)) got_done = 1'b1;
    end
    cmp($sformatf("done_seen_n%0d", n), 64'(got_done), 64'd1);
  endtask

  task automatic checkOutput(input string tag, input int n);
    for (int k = 0; k < n; k++)
      cmp($sformatf("%s_x%0d", tag, k), {32'h0, getx(n, k)}, {32'h0, exp_x[k][31:0]});
    cmp({tag, "_ovf"}, 64'((n == 6) ? ovf6 : ovf2), 64'(exp_ovf));
    cmp({tag, "_dz"},  64'((n == 6) ? dz6 : dz2),   64'(exp_dz));
  endtask

  initial begin
    rst = 1'b1;
    start6 = 1'b0; start2 = 1'b0;
    diag6 = '0; vec6 = '0; lower6 = '0;
    diag2 = '0; vec2 = '0; lower2 = '0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    cmp("rst_busy6", 64'(busy6), 64'd0);
    cmp("rst_done6", 64'(done6), 64'd0);
    cmp("rst_x6", 64'(x6 != '0), 64'd0);
    cmp("rst_flags6", 64'({ovf6, dz6}), 64'd0);
    cmp("rst_x2", x2, 64'd0);
    cmp("rst_busy2", 64'(busy2), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] identity solve, N=6, latency");
    clear_inputs();
    for (int k = 0; k < 6; k++) begin
      tb_d[k] = 64'sh10000;
      tb_b[k] = longint'(k + 1) * 65536;
    end
    applyStimulus(6);
    waitDone(6, 1'b0);
    cmp("lat_cycles", 64'(cycles), 64'd115);
    cmp("lat_busy", 64'(busy_cnt), 64'd115);
    checkOutput("ident", 6);
    for (int k = 0; k < 6; k++)
      cmp($sformatf("ident_const_x%0d", k), {32'h0, getx(6, k)}, 64'((k + 1) * 65536));
    @(negedge clk);
    cmp("done_pulse_width", 64'(done6), 64'd0);
    cmp("busy_after_done", 64'(busy6), 64'd0);

    $display("[TB] directed N=2 solve");
    clear_inputs();
    tb_d[0] = 64'sh20000; tb_d[1] = 64'sh40000; tb_l[1][0] = 64'sh8000;
    tb_b[0] = 64'sh10000; tb_b[1] = 64'sh30000;
    applyStimulus(2);
    waitDone(2, 1'b0);
    cmp("n2_cycles", 64'(cycles), 64'd15);
    checkOutput("n2", 2);
    cmp("n2_const_x0", {32'h0, getx(2, 0)}, 64'h3000);
    cmp("n2_const_x1", {32'h0, getx(2, 1)}, 64'hA000);
    @(negedge clk);

    $display("[TB] zero pivot");
    clear_inputs();
    tb_d[0] = 64'sh10000; tb_d[1] = 0;
    tb_b[0] = 64'sh10000; tb_b[1] = -64'sh10000;
    applyStimulus(2);
    waitDone(2, 1'b0);
    checkOutput("dz", 2);
    cmp("dz_const_x1", {32'h0, getx(2, 1)}, 64'h80000000);
    cmp("dz_const_flag", 64'(dz2), 64'd1);
    @(negedge clk);
    random_inputs(2);
    applyStimulus(2);
    waitDone(2, 1'b0);
    checkOutput("dz_clear", 2);
    cmp("dz_cleared", 64'(dz2), 64'd0);
    @(negedge clk);

    $display("[TB] quotient saturation");
    clear_inputs();
    tb_d[0] = 1; tb_d[1] = 1;
    tb_b[0] = 64'sh7FFF0000;
    applyStimulus(2);
    waitDone(2, 1'b0);
    checkOutput("sat", 2);
    cmp("sat_const_x0", {32'h0, getx(2, 0)}, 64'h7FFFFFFF);
    cmp("sat_const_ovf", 64'(ovf2), 64'd1);
    @(negedge clk);

    $display("[TB] randomized solves");
    for (int t = 0; t < 6; t++) begin
      random_inputs(2);
      applyStimulus(2);
      waitDone(2, 1'b0);
      checkOutput($sformatf("rnd2_%0d", t), 2);
      @(negedge clk);
    end
    for (int t = 0; t < 2; t++) begin
      random_inputs(6);
      applyStimulus(6);
      waitDone(6, 1'b0);
      checkOutput($sformatf("rnd6_%0d", t), 6);
      @(negedge clk);
    end

    $display("[TB] start ignored while busy and in DONE, back-to-back");
    random_inputs(6);
    applyStimulus(6);
    waitDone(6, 1'b1);
    cmp("poke_cycles", 64'(cycles), 64'd115);
    checkOutput("b2b_first", 6);
    random_inputs(6);
    applyStimulus(6);
    @(negedge clk);
    cmp("done_start_ignored", 64'(busy6), 64'd0);
    waitDone(6, 1'b0);
    cmp("b2b_cycles", 64'(cycles), 64'd115);
    checkOutput("b2b_second", 6);
    @(negedge clk);

    $display("[TB] reset mid-solve");
    random_inputs(6);
    applyStimulus(6);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start6 = 1'b0;
    end
    rst = 1'b1;
    #1;
    cmp("abort_busy", 64'(busy6), 64'd0);
    cmp("abort_done", 64'(done6), 64'd0);
    cmp("abort_x_zero", 64'(x6 != '0), 64'd0);
    cmp("abort_flags", 64'({ovf6, dz6}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done6) done_cnt++;
    end
    cmp("abort_no_done", 64'(done_cnt), 64'd0);
    random_inputs(6);
    applyStimulus(6);
    waitDone(6, 1'b0);
    cmp("post_rst_cycles", 64'(cycles), 64'd115);
    checkOutput("post_rst", 6);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
